// File: rtl/jig_pkg.sv
// rtl/jig_pkg.sv - shared constants, pin-byte layout and report FSM states for jig_pin_monitor
//
// Purpose: common definitions used by jig_pin_monitor and pin_sync_edge.
// Contents: default parameters, frame header byte, pin-byte bit positions,
//           report state enum and a helper that packs one pin result byte.
package jig_pkg;

  localparam int N_PINS_DEF  = 40;
  localparam int CNT_W_DEF   = 4;
  localparam int SYNC_FF_DEF = 2;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  // Pin result byte layout: {rise, fall, level, sat, cnt[3:0]}
  localparam int PB_RISE  = 7;
  localparam int PB_FALL  = 6;
  localparam int PB_LEVEL = 5;
  localparam int PB_SAT   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIN  = 2'd2,
    CSUM = 2'd3
  } state_e;

  function automatic logic [7:0] pack_pin_byte(
    input logic       rise,
    input logic       fall,
    input logic       level,
    input logic       sat,
    input logic [3:0] cnt4
  );
    logic [7:0] b;
    b           = {4'h0, cnt4};
    b[PB_RISE]  = rise;
    b[PB_FALL]  = fall;
    b[PB_LEVEL] = level;
    b[PB_SAT]   = sat;
    return b;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// rtl/pin_sync_edge.sv - per-pad synchroniser, edge flags and saturating toggle counter
//
// Purpose: synchronise one asynchronous pad, latch rise/fall flags, count
//          toggles with saturation, and present the packed result byte.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pad_i      in   raw asynchronous pad
//   clear_i    in   zero counter and flags (wins over a coincident edge)
//   pin_byte_o out  {rise, fall, level, sat, cnt[3:0]}
module pin_sync_edge
  import jig_pkg::*;
#(
  parameter int SYNC_FF = SYNC_FF_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_i,
  input  logic       clear_i,
  output logic [7:0] pin_byte_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_FF-1:0] sync_q, sync_d;
  logic               prev_q, prev_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        level;
  logic        rise_ev;
  logic        fall_ev;
  logic        sat;
  logic [31:0] cnt_ext;
  logic [3:0]  cnt4;

  always_comb begin
    sync_d  = {sync_q[SYNC_FF-2:0], pad_i};
    level   = sync_q[SYNC_FF-1];
    prev_d  = level;
    rise_ev = level & ~prev_q;
    fall_ev = ~level & prev_q;
    sat     = (cnt_q == CNT_MAX);

    rise_d = rise_q;
    fall_d = fall_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      // Clear takes priority; an edge seen this cycle is deliberately lost.
      rise_d = 1'b0;
      fall_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (rise_ev) rise_d = 1'b1;
      if (fall_ev) fall_d = 1'b1;
      if ((rise_ev || fall_ev) && !sat) cnt_d = cnt_q + CNT_W'(1);
    end

    // Wide counters report as a 4-bit value clipped at 15.
    cnt_ext = 32'(cnt_q);
    cnt4    = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

    pin_byte_o = pack_pin_byte(rise_q, fall_q, level, sat, cnt4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/jig_pin_monitor.sv
// rtl/jig_pin_monitor.sv - test-jig pad monitor with snapshot and framed byte report
//
// Purpose: monitor every jig pad for edges and toggle counts; on start,
//          snapshot all results and stream A5, one byte per pin, XOR checksum.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   pins_i     in   raw asynchronous pads, bit i = jig pin i
//   clear_i    in   pulse: zero all counters and edge flags
//   start_i    in   pulse: snapshot and begin report (ignored while busy)
//   busy_o     out  report in progress
//   tx_data_o  out  report byte
//   tx_valid_o out  tx_data_o valid
//   tx_ready_i in   byte accepted when valid && ready
module jig_pin_monitor
  import jig_pkg::*;
#(
  parameter int N_PINS  = N_PINS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int SYNC_FF = SYNC_FF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_PINS-1:0] pins_i,
  input  logic              clear_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  localparam int IDX_W = (N_PINS > 1) ? $clog2(N_PINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PINS - 1);

  logic [7:0] live_byte [N_PINS];
  logic [7:0] live_csum;

  for (genvar g = 0; g < N_PINS; g++) begin : g_pin
    pin_sync_edge #(
      .SYNC_FF (SYNC_FF),
      .CNT_W   (CNT_W)
    ) u_pin (
      .clk        (clk),
      .rst        (rst),
      .pad_i      (pins_i[g]),
      .clear_i    (clear_i),
      .pin_byte_o (live_byte[g])
    );
  end

  always_comb begin
    live_csum = 8'h00;
    for (int i = 0; i < N_PINS; i++) live_csum = live_csum ^ live_byte[i];
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       snap_q [N_PINS];
  logic [7:0]       snap_d [N_PINS];
  logic [7:0]       csum_q, csum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             accept;
  logic             capture;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    capture    = 1'b0;
    accept     = tx_valid_q & tx_ready_i;
    idx_nxt    = idx_q + IDX_W'(1);

    // The output register always holds the byte for the current state, so
    // each acceptance loads the following byte for the next cycle.
    case (state_q)
      IDLE: begin
        if (start_i) begin
          capture    = 1'b1;
          csum_d     = live_csum;
          idx_d      = '0;
          state_d    = HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = FRAME_HDR;
        end
      end
      HDR: begin
        if (accept) begin
          state_d   = PIN;
          idx_d     = '0;
          tx_data_d = snap_q[0];
        end
      end
      PIN: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d   = CSUM;
            tx_data_d = csum_q;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = snap_q[idx_nxt];
          end
        end
      end
      CSUM: begin
        if (accept) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    if (capture) begin
      for (int i = 0; i < N_PINS; i++) snap_d[i] = live_byte[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      csum_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      for (int i = 0; i < N_PINS; i++) snap_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      snap_q     <= snap_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

endmodule

// File: tb/tb_jig_pin_monitor.sv
// tb/tb_jig_pin_monitor.sv - scoreboard bench for jig_pin_monitor
module tb_jig_pin_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] pins_i;
  logic        clear_i;
  logic        start_i;
  logic        busy_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  jig_pin_monitor #(
    .N_PINS  (40),
    .CNT_W   (4),
    .SYNC_FF (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pins_i     (pins_i),
    .clear_i    (clear_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         rx_count = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_pin [40];
  logic [7:0] mon_exp;

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (!rst && tx_valid_o && tx_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte pos %0d got %02h exp none", rx_count, tx_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data_o !== mon_exp) begin
          errors++;
          $display("FAIL frame_byte pos %0d got %02h exp %02h", rx_count, tx_data_o, mon_exp);
        end
      end
      rx_count++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < 40; i++) exp_pin[i] = 8'h00;
  endtask

  task automatic push_frame();
    logic [7:0] cs;
    cs       = 8'h00;
    rx_count = 0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(exp_pin[i]);
      cs = cs ^ exp_pin[i];
    end
    exp_q.push_back(cs);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
  endtask

  task automatic wait_rx(input int k);
    int n;
    n = 0;
    while (rx_count < k && n < 1000) begin
      cycles(1);
      n++;
    end
    check("wait_rx_timeout", (rx_count >= k), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy_o && n < 1000) begin
      cycles(1);
      n++;
    end
    check("frame_done", busy_o, 0);
    check("frame_len", rx_count, 42);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pins_i     = '0;
    clear_i    = 1'b0;
    start_i    = 1'b0;
    tx_ready_i = 1'b1;
    rst        = 1'b1;
    zero_exp();
    cycles(3);
    rst = 1'b0;
    cycles(1);
    check("reset_valid", tx_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_data", tx_data_o, 8'h00);

    // All pads idle: header, forty zero bytes, zero checksum.
    push_frame();
    pulse_start();
    wait_done();

    // Pin 3 pulses once: rise, fall, level 0, cnt 2.
    pins_i[3] = 1'b1;
    cycles(3);
    pins_i[3] = 1'b0;
    cycles(4);
    exp_pin[3] = 8'hC2;
    push_frame();
    pulse_start();
    wait_done();

    // Pin 7 toggles 21 times ending high: saturated; ready stalls on its byte.
    pulse_clear();
    zero_exp();
    for (int i = 0; i < 21; i++) begin
      pins_i[7] = ~pins_i[7];
      cycles(2);
    end
    cycles(4);
    exp_pin[7] = 8'hFF;
    push_frame();
    pulse_start();
    wait_rx(8);
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", tx_valid_o, 1);
      check("stall_data", tx_data_o, 8'hFF);
      cycles(1);
    end
    tx_ready_i = 1'b1;
    wait_done();

    // Pin 5 edge reaches its counter in the same cycle as clear: edge lost.
    pulse_clear();
    zero_exp();
    pins_i[5] = 1'b1;
    cycles(2);
    clear_i = 1'b1;
    cycles(1);
    clear_i = 1'b0;
    cycles(4);
    exp_pin[5] = 8'h20;
    exp_pin[7] = 8'h20;
    push_frame();
    pulse_start();
    wait_rx(5);
    pulse_start();
    wait_done();
    cycles(5);
    check("no_second_frame_valid", tx_valid_o, 0);
    check("no_second_frame_q", exp_q.size(), 0);

    // Reset mid-frame, then a clean frame; pads 5 and 7 re-detect as rises.
    push_frame();
    pulse_start();
    wait_rx(10);
    rst = 1'b1;
    exp_q.delete();
    cycles(1);
    rst = 1'b0;
    check("rst_mid_valid", tx_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_data", tx_data_o, 8'h00);
    cycles(6);
    exp_pin[5] = 8'hA1;
    exp_pin[7] = 8'hA1;
    push_frame();
    pulse_start();
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
